// File: rtl/pipe_control_unit.sv
// Pipeline control for a 5-stage MIPS-style core: ID decode, ID/EX, EX/MEM and
// MEM/WB control registers, load-use stall, branch/jump redirect and flush.
module pipe_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUCTL_W   = 4,
    parameter int LINK_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           id_instr,
    input  logic                  id_valid,
    input  logic                  ex_zero,
    output logic [1:0]            pc_sel,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic [ALUCTL_W-1:0]   ex_alu_ctl,
    output logic [1:0]            ex_alu_src,
    output logic                  ex_beq,
    output logic                  ex_bne,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_size,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_link,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  illegal
);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(4'b0000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(4'b0001);
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(4'b0010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(4'b0110);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(4'b0111);
    localparam logic [ALUCTL_W-1:0] ALU_NOR = ALUCTL_W'(4'b1100);
    localparam logic [ALUCTL_W-1:0] ALU_XOR = ALUCTL_W'(4'b1101);

    typedef struct packed {
        logic [ALUCTL_W-1:0] alu_ctl;
        logic [1:0]          alu_src;
        logic                beq;
        logic                bne;
    } ex_ctl_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] size;
    } mem_ctl_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  link;
        logic [REG_ADDR_W-1:0] dest;
    } wb_ctl_t;

    typedef struct packed {
        ex_ctl_t  ex;
        mem_ctl_t mem;
        wb_ctl_t  wb;
    } idex_t;

    typedef struct packed {
        mem_ctl_t mem;
        wb_ctl_t  wb;
    } exmem_t;

    // alu_ctl is the most significant field, so a bubble is ADD over zeros.
    localparam idex_t IDEX_BUBBLE = idex_t'({ALU_ADD, {($bits(idex_t)-ALUCTL_W){1'b0}}});

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign op           = id_instr[31:26];
    assign rs           = id_instr[25:21];
    assign rt           = id_instr[20:16];
    assign rd           = id_instr[15:11];
    assign funct        = id_instr[5:0];
    assign unused_shamt = ^id_instr[10:6];

    idex_t  idex_q, idex_d, dec;
    exmem_t exmem_q, exmem_d;
    wb_ctl_t memwb_q, memwb_d;

    logic                  legal, uses_rt, is_j, is_jr, wr;
    logic [REG_ADDR_W-1:0] dst;

    always_comb begin
        dec     = IDEX_BUBBLE;
        legal   = 1'b1;
        uses_rt = 1'b0;
        is_j    = 1'b0;
        is_jr   = 1'b0;
        wr      = 1'b0;
        dst     = REG_ADDR_W'(rt);
        case (op)
            6'h00: begin
                uses_rt = 1'b1;
                wr      = 1'b1;
                dst     = REG_ADDR_W'(rd);
                case (funct)
                    6'h20: dec.ex.alu_ctl = ALU_ADD;
                    6'h22: dec.ex.alu_ctl = ALU_SUB;
                    6'h24: dec.ex.alu_ctl = ALU_AND;
                    6'h25: dec.ex.alu_ctl = ALU_OR;
                    6'h26: dec.ex.alu_ctl = ALU_XOR;
                    6'h27: dec.ex.alu_ctl = ALU_NOR;
                    6'h2a: dec.ex.alu_ctl = ALU_SLT;
                    6'h08: begin is_jr = 1'b1; wr = 1'b0; uses_rt = 1'b0; end
                    default: legal = 1'b0;
                endcase
            end
            6'h08, 6'h0f: begin dec.ex.alu_src = 2'b01; wr = 1'b1; end
            6'h0a: begin dec.ex.alu_ctl = ALU_SLT; dec.ex.alu_src = 2'b01; wr = 1'b1; end
            6'h0c: begin dec.ex.alu_ctl = ALU_AND; dec.ex.alu_src = 2'b10; wr = 1'b1; end
            6'h0d: begin dec.ex.alu_ctl = ALU_OR;  dec.ex.alu_src = 2'b10; wr = 1'b1; end
            6'h0e: begin dec.ex.alu_ctl = ALU_XOR; dec.ex.alu_src = 2'b10; wr = 1'b1; end
            6'h23, 6'h21, 6'h20: begin
                dec.ex.alu_src    = 2'b01;
                dec.mem.rd        = 1'b1;
                dec.mem.size      = (op == 6'h23) ? 2'b00 : (op == 6'h21) ? 2'b01 : 2'b10;
                dec.wb.mem_to_reg = 1'b1;
                wr                = 1'b1;
            end
            6'h2b, 6'h29, 6'h28: begin
                dec.ex.alu_src = 2'b01;
                dec.mem.wr     = 1'b1;
                dec.mem.size   = (op == 6'h2b) ? 2'b00 : (op == 6'h29) ? 2'b01 : 2'b10;
                uses_rt        = 1'b1;
            end
            6'h04: begin dec.ex.alu_ctl = ALU_SUB; dec.ex.beq = 1'b1; uses_rt = 1'b1; end
            6'h05: begin dec.ex.alu_ctl = ALU_SUB; dec.ex.bne = 1'b1; uses_rt = 1'b1; end
            6'h02: is_j = 1'b1;
            6'h03: begin is_j = 1'b1; wr = 1'b1; dst = REG_ADDR_W'(LINK_REG); dec.wb.link = 1'b1; end
            default: legal = 1'b0;
        endcase
        dec.wb.dest      = wr ? dst : '0;
        dec.wb.reg_write = wr && (dst != '0);
    end

    logic take_br, load_use;
    assign take_br  = (idex_q.ex.beq & ex_zero) | (idex_q.ex.bne & ~ex_zero);
    assign load_use = idex_q.mem.rd && (idex_q.wb.dest != '0) &&
                      ((idex_q.wb.dest == REG_ADDR_W'(rs)) ||
                       (uses_rt && (idex_q.wb.dest == REG_ADDR_W'(rt))));

    // Redirect priority: taken branch in EX, then illegal, then load-use, then ID jumps.
    always_comb begin
        idex_d     = IDEX_BUBBLE;
        pc_sel     = 2'b00;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        illegal    = 1'b0;
        if (!rst_n) begin
            idex_d = IDEX_BUBBLE;
        end else if (take_br) begin
            pc_sel     = 2'b01;
            ifid_flush = 1'b1;
        end else if (id_valid) begin
            if (!legal) begin
                illegal = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
            end else begin
                idex_d = dec;
                if (is_j)  begin pc_sel = 2'b10; ifid_flush = 1'b1; end
                if (is_jr) begin pc_sel = 2'b11; ifid_flush = 1'b1; end
            end
        end
    end

    assign exmem_d = '{mem: idex_q.mem, wb: idex_q.wb};
    assign memwb_d = exmem_q.wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= IDEX_BUBBLE;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alu_ctl    = idex_q.ex.alu_ctl;
    assign ex_alu_src    = idex_q.ex.alu_src;
    assign ex_beq        = idex_q.ex.beq;
    assign ex_bne        = idex_q.ex.bne;
    assign mem_read      = exmem_q.mem.rd;
    assign mem_write     = exmem_q.mem.wr;
    assign mem_size      = exmem_q.mem.size;
    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_link       = memwb_q.link;
    assign wb_dest       = memwb_q.dest;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: decode latency, load-use stall,
// branch/jump redirect, illegal detection and mid-operation reset.
module tb_pipe_control_unit;
    logic        clk, rst_n, id_valid, ex_zero;
    logic [31:0] id_instr;
    logic [1:0]  pc_sel, ex_alu_src, mem_size;
    logic        pc_stall, ifid_stall, ifid_flush, ex_beq, ex_bne;
    logic        mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_link, illegal;
    logic [3:0]  ex_alu_ctl;
    logic [4:0]  wb_dest;
    int n_cmp = 0;
    int n_err = 0;

    pipe_control_unit dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .ex_zero(ex_zero),
        .pc_sel(pc_sel), .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .ex_alu_ctl(ex_alu_ctl), .ex_alu_src(ex_alu_src), .ex_beq(ex_beq), .ex_bne(ex_bne),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_link(wb_link),
        .wb_dest(wb_dest), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_instr = '0; id_valid = 1'b0; ex_zero = 1'b0;
        // reset: jal in ID must not redirect while reset is held
        tick();
        id_instr = jtype(6'h03, 26'h10); id_valid = 1'b1; #1;
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_alu_ctl", ex_alu_ctl, 4'b0010);
        chk("rst_wb_we", wb_reg_write, 0);
        chk("rst_illegal", illegal, 0);
        tick();

        // add r3,r1,r2 on the first edge after release
        rst_n = 1'b1; id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); id_valid = 1'b1; #1;
        chk("add_pc_sel", pc_sel, 0);
        tick(); id_valid = 1'b0;
        chk("add_ex_ctl", ex_alu_ctl, 4'b0010);
        chk("add_ex_src", ex_alu_src, 0);
        tick();
        chk("add_mem_rd", mem_read, 0);
        tick();
        chk("add_wb_we", wb_reg_write, 1);
        chk("add_wb_dest", wb_dest, 3);

        // lw r4 ; add r5,r4,r1 -> one-cycle stall
        id_instr = itype(6'h23, 5'd1, 5'd4, 16'h0); id_valid = 1'b1; #1;
        chk("lw_no_stall", pc_stall, 0);
        tick();
        chk("lw_ex_src", ex_alu_src, 2'b01);
        id_instr = rtype(5'd4, 5'd1, 5'd5, 6'h20); #1;
        chk("lu_pc_stall", pc_stall, 1);
        chk("lu_ifid_stall", ifid_stall, 1);
        tick();
        chk("lu_bubble_src", ex_alu_src, 0);
        chk("lu_lw_mem_rd", mem_read, 1);
        chk("lu_lw_size", mem_size, 0);
        chk("lu_stall_once", pc_stall, 0);
        tick(); id_valid = 1'b0;
        chk("lu_lw_wb_m2r", wb_mem_to_reg, 1);
        chk("lu_lw_wb_dest", wb_dest, 4);
        chk("lu_bubble_mem", mem_read, 0);
        tick();
        chk("lu_bubble_wb", wb_reg_write, 0);
        tick();
        chk("lu_add_wb_we", wb_reg_write, 1);
        chk("lu_add_wb_dest", wb_dest, 5);

        // sb streams byte size into MEM
        id_instr = itype(6'h28, 5'd1, 5'd2, 16'h4); id_valid = 1'b1;
        tick(); id_valid = 1'b0;
        tick();
        chk("sb_mem_wr", mem_write, 1);
        chk("sb_size", mem_size, 2'b10);

        // beq taken in EX beats j in ID
        id_instr = itype(6'h04, 5'd1, 5'd2, 16'h8); id_valid = 1'b1;
        tick();
        chk("beq_ex_beq", ex_beq, 1);
        chk("beq_ex_ctl", ex_alu_ctl, 4'b0110);
        id_instr = jtype(6'h02, 26'h40); ex_zero = 1'b1; #1;
        chk("br_pc_sel", pc_sel, 2'b01);
        chk("br_flush", ifid_flush, 1);
        chk("br_no_stall", pc_stall, 0);
        tick();
        chk("br_j_squashed", ex_beq, 0);
        ex_zero = 1'b0; id_valid = 1'b0; #1;
        chk("br_idle_pc_sel", pc_sel, 0);
        chk("br_idle_flush", ifid_flush, 0);

        // bne not taken: j in ID redirects
        id_instr = itype(6'h05, 5'd1, 5'd2, 16'h8); id_valid = 1'b1;
        tick();
        chk("bne_ex_bne", ex_bne, 1);
        id_instr = jtype(6'h02, 26'h40); ex_zero = 1'b1; #1;
        chk("bne_nt_j_sel", pc_sel, 2'b10);
        tick(); ex_zero = 1'b0; id_valid = 1'b0;

        // jal writes link three cycles later
        id_instr = jtype(6'h03, 26'h80); id_valid = 1'b1; #1;
        chk("jal_pc_sel", pc_sel, 2'b10);
        chk("jal_flush", ifid_flush, 1);
        tick(); id_valid = 1'b0;
        tick();
        tick();
        chk("jal_wb_link", wb_link, 1);
        chk("jal_wb_dest", wb_dest, 31);
        chk("jal_wb_we", wb_reg_write, 1);

        // ori / xori zero-extend, then illegal opcode 63
        id_instr = itype(6'h0d, 5'd0, 5'd6, 16'h5); id_valid = 1'b1;
        tick();
        chk("ori_src", ex_alu_src, 2'b10);
        chk("ori_ctl", ex_alu_ctl, 4'b0001);
        id_instr = itype(6'h0e, 5'd0, 5'd6, 16'h5);
        tick();
        chk("xori_src", ex_alu_src, 2'b10);
        chk("xori_ctl", ex_alu_ctl, 4'b1101);
        id_instr = {6'h3f, 26'h0}; #1;
        chk("ill_pulse", illegal, 1);
        chk("ill_no_stall", pc_stall, 0);
        tick();
        chk("ill_bubble", ex_alu_src, 0);
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h3f); #1;
        chk("ill_funct", illegal, 1);
        id_valid = 1'b0; #1;
        chk("ill_invalid", illegal, 0);

        // add r0 never writes
        id_instr = rtype(5'd1, 5'd2, 5'd0, 6'h20); id_valid = 1'b1;
        tick(); id_valid = 1'b0;
        tick();
        tick();
        chk("r0_wb_we", wb_reg_write, 0);

        // jr dependent on lw: stall, then redirect
        id_instr = itype(6'h23, 5'd1, 5'd7, 16'h0); id_valid = 1'b1;
        tick();
        id_instr = rtype(5'd7, 5'd0, 5'd0, 6'h08); #1;
        chk("jr_stall", pc_stall, 1);
        chk("jr_stall_sel", pc_sel, 0);
        tick();
        chk("jr_no_stall", pc_stall, 0);
        chk("jr_pc_sel", pc_sel, 2'b11);
        chk("jr_flush", ifid_flush, 1);
        tick(); id_valid = 1'b0;
        tick();

        // reset asserted mid-stall
        id_instr = itype(6'h23, 5'd1, 5'd4, 16'h0); id_valid = 1'b1;
        tick();
        id_instr = rtype(5'd4, 5'd1, 5'd5, 6'h20); #1;
        chk("mr_stall", pc_stall, 1);
        rst_n = 1'b0; #1;
        chk("mr_pc_stall", pc_stall, 0);
        chk("mr_ifid_stall", ifid_stall, 0);
        chk("mr_alu_ctl", ex_alu_ctl, 4'b0010);
        chk("mr_alu_src", ex_alu_src, 0);
        chk("mr_mem_rd", mem_read, 0);
        chk("mr_wb_m2r", wb_mem_to_reg, 0);
        tick();
        rst_n = 1'b1; #1;
        chk("mr_rel_stall", pc_stall, 0);
        tick(); id_valid = 1'b0;
        tick();
        tick();
        chk("mr_add_wb_we", wb_reg_write, 1);
        chk("mr_add_wb_dest", wb_dest, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter ALUCTL_W, default 4, meaning ALU control width (and=0000, or=0001, add=0010, sub=0110, slt=0111, nor=1100, xor=1101).
REQ-003 SHALL have parameter LINK_REG, default 31, meaning the jal destination register.
REQ-004 SHALL have port clk, input, 1, the single clock with all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port id_instr, input, 32, the IF/ID instruction word.
REQ-007 SHALL have port id_valid, input, 1, meaning id_instr holds a real instruction.
REQ-008 SHALL have port ex_zero, input, 1, the ALU zero flag of the EX-stage instruction.
REQ-009 SHALL have port pc_sel, output, 2, the next-PC source: 00 PC+4, 01 branch target, 10 jump target, 11 register (jr).
REQ-010 SHALL have ports pc_stall and ifid_stall, output, 1 each, meaning hold PC and hold IF/ID.
REQ-011 SHALL have port ifid_flush, output, 1, meaning load a NOP into IF/ID.
REQ-012 SHALL have EX outputs ex_alu_ctl (ALUCTL_W), ex_alu_src (2; 00 reg, 01 sign-extend, 10 zero-extend), ex_beq, ex_bne.
REQ-013 SHALL have MEM outputs mem_read, mem_write, mem_size (2; 00 word, 01 half, 10 byte).
REQ-014 SHALL have WB outputs wb_reg_write, wb_mem_to_reg, wb_link (1 each) and wb_dest (REG_ADDR_W).
REQ-015 SHALL have port illegal, output, 1, a one-cycle pulse on an undecodable valid instruction.

Function
REQ-016 SHALL decode the opcode in ID combinationally, and SHALL decode funct as well when opcode=0.
REQ-017 SHALL support R-type add, sub, and, or, nor, xor, slt, jr.
REQ-018 SHALL support I-type addi, andi, ori, xori, slti, lui, lw, lh, lb, sw, sh, sb, beq, bne.
REQ-019 SHALL support J-type j and jal.
REQ-020 SHALL use zero-extend for andi, ori and xori, and sign-extend for all other immediates.
REQ-021 SHALL select the destination register as rd for R-type, rt for I-type loads and ALU immediates, and LINK_REG for jal.
REQ-022 SHALL force wb_reg_write=0 whenever the destination is register 0.
REQ-023 SHALL register the control bundle into the ID/EX, EX/MEM and MEM/WB stages.
REQ-024 SHALL present an instruction's controls on ex_* 1 cycle after ID, on mem_* after 2 cycles and on wb_* after 3 cycles.
REQ-025 SHALL define a bubble as all-zero controls, with ex_alu_ctl=add and wb_dest=0.
REQ-026 SHALL, on a load-use hazard, assert pc_stall=1 and ifid_stall=1 for exactly 1 cycle and insert a bubble into ID/EX.
REQ-027 SHALL detect a load-use hazard when the ID/EX stage holds a load with dest≠0 and dest equals ID rs, or equals ID rt for an R-type, branch or store.
REQ-028 SHALL take a branch when ex_beq&ex_zero or ex_bne&!ex_zero, and then drive pc_sel=01 and ifid_flush=1 and bubble ID/EX in the same cycle, giving a 2-instruction penalty.
REQ-029 SHALL, for j or jal in ID, drive pc_sel=10 and ifid_flush=1 that cycle, and the jump SHALL proceed down the pipe (jal writes the link).
REQ-030 SHALL, for jr in ID, drive pc_sel=11 and ifid_flush=1, and if jr is load-use dependent SHALL stall first, then redirect.
REQ-031 SHALL give a taken branch in EX priority over the load-use stall and the ID jump/jr; stalls SHALL be deasserted and the ID instruction squashed.
REQ-032 SHALL treat id_valid=0 as a bubble, with no stall, redirect or illegal pulse.
REQ-033 SHALL, for an illegal opcode or funct with id_valid=1, insert a bubble and pulse illegal=1 for that cycle.
REQ-034 SHALL hold pc_sel=00, with no flush, when nothing redirects.

Reset
REQ-035 SHALL, on rst_n=0, clear all pipeline stages to bubble immediately and asynchronously.
REQ-036 SHALL drive all outputs to 0 during reset, except ex_alu_ctl=add.
REQ-037 SHALL discard any in-flight stall or redirect when reset is asserted mid-operation.
REQ-038 SHALL treat the first edge after rst_n rises as a normal ID cycle.

Verification
REQ-039 SHALL cover: add r3,r1,r2 streamed -> ex_alu_ctl=0010 at +1, wb_reg_write=1 with wb_dest=3 at +3.
REQ-040 SHALL cover: lw r4 then add r5,r4,r1 -> pc_stall=1 and ifid_stall=1 for 1 cycle, a bubble in EX, and the add at EX one cycle later.
REQ-041 SHALL cover: beq in EX with ex_zero=1 while j is in ID -> pc_sel=01 and ifid_flush=1, with j squashed (never reaches WB).
REQ-042 SHALL cover: jal in ID -> pc_sel=10, then wb_link=1 and wb_dest=31 three cycles later.
REQ-043 SHALL cover: ori and xori -> ex_alu_src=10; an opcode of 63 -> illegal pulse and a bubble.
REQ-044 SHALL cover: rst_n low mid-stall -> all outputs at reset values before the next edge, and normal decode resuming after release.
